vga_timing_gen: RTL and testbench

Generates 640x480@60 Hz VGA raster timing for the display path. Produces the pixel coordinates `DrawX`/`DrawY`, the `blank` qualifier, and active-low `hs`/`vs` sync strobes from the 50 MHz system clock. It also keeps a per-frame counter, `deltatime`, that drives colour animation. It sits upstream of `color_mapper`, which consumes `DrawX`, `DrawY`, `blank` and `deltatime`. The sync and blank outputs are delayed to line up with that block's synchronous ROM reads.

---
 rtl/vga_timing_gen.sv | 131 +++++++++++++
 tb/tb_vga_timing_gen.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : 640x480@60 Hz VGA raster timing from a 50 MHz clock. Emits
//               undelayed pixel coordinates, pipeline-aligned hs/vs/blank
//               strobes, a per-frame pulse and a free-running frame counter.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
  parameter int H_VIS      = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_VIS      = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int PIPE_DELAY = 1    // legal range 1..4
) (
  input  logic        Clk,
  input  logic        Reset_n,
  output logic        pixel_clk,
  output logic [9:0]  DrawX,
  output logic [9:0]  DrawY,
  output logic        hs,
  output logic        vs,
  output logic        blank,
  output logic        frame_start,
  output logic [12:0] deltatime
);

  localparam logic [9:0] c_H_LAST     = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] c_V_LAST     = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] c_H_VIS      = 10'(H_VIS);
  localparam logic [9:0] c_V_VIS      = 10'(V_VIS);
  localparam logic [9:0] c_HS_FIRST   = 10'(H_VIS + H_FP);
  localparam logic [9:0] c_HS_LAST    = 10'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [9:0] c_VS_FIRST   = 10'(V_VIS + V_FP);
  localparam logic [9:0] c_VS_LAST    = 10'(V_VIS + V_FP + V_SYNC - 1);
  // Idle strobe pattern {hs, vs, blank}: syncs inactive, pixel blanked.
  localparam logic [2:0] c_STROBE_IDLE = 3'b110;

  logic        r_ph;
  logic        r_pixel_clk;
  logic [9:0]  r_hc;
  logic [9:0]  r_vc;
  logic        r_frame_start;
  logic [12:0] r_deltatime;

  logic        w_tick;
  logic        w_h_end;
  logic        w_v_end;
  logic        w_hs_raw;
  logic        w_vs_raw;
  logic        w_blank_raw;
  logic [2:0]  w_raw;

  assign w_tick      = r_ph;
  assign w_h_end     = (r_hc == c_H_LAST);
  assign w_v_end     = (r_vc == c_V_LAST);

  assign w_hs_raw    = ~((r_hc >= c_HS_FIRST) && (r_hc <= c_HS_LAST));
  assign w_vs_raw    = ~((r_vc >= c_VS_FIRST) && (r_vc <= c_VS_LAST));
  assign w_blank_raw = (r_hc < c_H_VIS) && (r_vc < c_V_VIS);
  assign w_raw       = {w_hs_raw, w_vs_raw, w_blank_raw};

  // Divide-by-two phase; the pixel clock output is the phase one Clk later.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_ph        <= 1'b0;
      r_pixel_clk <= 1'b0;
    end else begin
      r_ph        <= ~r_ph;
      r_pixel_clk <= r_ph;
    end
  end

  // Raster counters and frame counter; all wraps land on the same tick.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_hc          <= 10'd0;
      r_vc          <= 10'd0;
      r_frame_start <= 1'b0;
      r_deltatime   <= 13'd0;
    end else begin
      r_frame_start <= w_tick && w_h_end && w_v_end;
      if (w_tick) begin
        if (w_h_end) begin
          r_hc <= 10'd0;
          if (w_v_end) begin
            r_vc        <= 10'd0;
            r_deltatime <= r_deltatime + 13'd1;
          end else begin
            r_vc <= r_vc + 10'd1;
          end
        end else begin
          r_hc <= r_hc + 10'd1;
        end
      end
    end
  end

  // Strobe delay chain so hs/vs/blank line up with the sink's ROM latency.
  generate
    for (genvar g = 0; g < PIPE_DELAY; g++) begin : g_stage
      logic [2:0] r_q;
      if (g == 0) begin : g_head
        // First stage samples the raw strobes.
        always_ff @(posedge Clk or negedge Reset_n) begin
          if (!Reset_n) r_q <= c_STROBE_IDLE;
          else          r_q <= w_raw;
        end
      end else begin : g_tail
        // Later stages shift the previous stage forward.
        always_ff @(posedge Clk or negedge Reset_n) begin
          if (!Reset_n) r_q <= c_STROBE_IDLE;
          else          r_q <= g_stage[g-1].r_q;
        end
      end
    end
  endgenerate

  assign pixel_clk        = r_pixel_clk;
  assign DrawX            = r_hc;
  assign DrawY            = r_vc;
  assign {hs, vs, blank}  = g_stage[PIPE_DELAY-1].r_q;
  assign frame_start      = r_frame_start;
  assign deltatime        = r_deltatime;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_timing_gen
// Description : Bench for vga_timing_gen. Three instances (full geometry with
//               delays 1 and 4, plus a reduced geometry for frame-level work)
//               compared every cycle against an arithmetic raster model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

  typedef struct packed {
    logic        pclk;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        hs;
    logic        vs;
    logic        blank;
    logic        fs;
    logic [12:0] dt;
  } vout_t;

  typedef struct {
    int unsigned hv, hfp, hsw, hbp, vv, vfp, vsw, vbp, d;
  } geo_t;

  typedef struct {
    int unsigned k;
    int          x;
    int          y;
    logic        hs;
    logic        vs;
    logic        blank;
  } vec_t;

  logic Clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst_s_n = 1'b0;

  always #10 Clk = ~Clk;

  logic a_pclk, a_hs, a_vs, a_blank, a_fs;
  logic b_pclk, b_hs, b_vs, b_blank, b_fs;
  logic s_pclk, s_hs, s_vs, s_blank, s_fs;
  logic [9:0] a_x, a_y, b_x, b_y, s_x, s_y;
  logic [12:0] a_dt, b_dt, s_dt;

  vga_timing_gen #(.PIPE_DELAY(1)) dut_a (
    .Clk(Clk), .Reset_n(rst_n), .pixel_clk(a_pclk), .DrawX(a_x), .DrawY(a_y),
    .hs(a_hs), .vs(a_vs), .blank(a_blank), .frame_start(a_fs), .deltatime(a_dt));

  vga_timing_gen #(.PIPE_DELAY(4)) dut_b (
    .Clk(Clk), .Reset_n(rst_n), .pixel_clk(b_pclk), .DrawX(b_x), .DrawY(b_y),
    .hs(b_hs), .vs(b_vs), .blank(b_blank), .frame_start(b_fs), .deltatime(b_dt));

  vga_timing_gen #(
    .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_VIS(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .PIPE_DELAY(2)
  ) dut_s (
    .Clk(Clk), .Reset_n(rst_s_n), .pixel_clk(s_pclk), .DrawX(s_x), .DrawY(s_y),
    .hs(s_hs), .vs(s_vs), .blank(s_blank), .frame_start(s_fs), .deltatime(s_dt));

  vout_t act_a, act_b, act_s;
  assign act_a = {a_pclk, a_x, a_y, a_hs, a_vs, a_blank, a_fs, a_dt};
  assign act_b = {b_pclk, b_x, b_y, b_hs, b_vs, b_blank, b_fs, b_dt};
  assign act_s = {s_pclk, s_x, s_y, s_hs, s_vs, s_blank, s_fs, s_dt};

  geo_t g_a, g_b, g_s;
  int unsigned k_a = 0;
  int unsigned k_s = 0;
  int unsigned bias_s = 0;
  int total = 0;
  int passed = 0;

  // Clk edges seen since the most recent reset release.
  always @(posedge Clk or negedge rst_n)
    if (!rst_n) k_a <= 0; else k_a <= k_a + 1;

  always @(posedge Clk or negedge rst_s_n)
    if (!rst_s_n) k_s <= 0; else k_s <= k_s + 1;

  // Expected outputs after k edges: pixel index is k/2, strobes are the
  // geometry rules applied to the pixel index d edges earlier.
  function automatic vout_t ref_out(input int unsigned k, input geo_t g,
                                    input int unsigned bias);
    vout_t r;
    int unsigned ht, vt, ft, p, pd, hcd, vcd;
    ht = g.hv + g.hfp + g.hsw + g.hbp;
    vt = g.vv + g.vfp + g.vsw + g.vbp;
    ft = ht * vt;
    p  = k / 2;
    r.pclk = (k == 0) ? 1'b0 : 1'((k - 1) % 2);
    r.x    = 10'(p % ht);
    r.y    = 10'((p / ht) % vt);
    r.fs   = (k != 0) && (k % 2 == 0) && (p % ft == 0);
    r.dt   = 13'((p / ft + bias) % 8192);
    if (k < g.d) begin
      r.hs = 1'b1; r.vs = 1'b1; r.blank = 1'b0;
    end else begin
      pd  = (k - g.d) / 2;
      hcd = pd % ht;
      vcd = (pd / ht) % vt;
      r.hs    = !((hcd >= g.hv + g.hfp) && (hcd < g.hv + g.hfp + g.hsw));
      r.vs    = !((vcd >= g.vv + g.vfp) && (vcd < g.vv + g.vfp + g.vsw));
      r.blank = (hcd < g.hv) && (vcd < g.vv);
    end
    return r;
  endfunction

  task automatic chk(input string nm, input int unsigned k, input vout_t got, input vout_t exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s k=%0d: got pclk=%0d x=%0d y=%0d hs=%0d vs=%0d blank=%0d fs=%0d dt=%0d, expected pclk=%0d x=%0d y=%0d hs=%0d vs=%0d blank=%0d fs=%0d dt=%0d",
                  nm, k, got.pclk, got.x, got.y, got.hs, got.vs, got.blank, got.fs, got.dt,
                  exp.pclk, exp.x, exp.y, exp.hs, exp.vs, exp.blank, exp.fs, exp.dt);
  endtask

  task automatic chk_int(input string nm, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
  endtask

  task automatic check_models();
    chk("model_a", k_a, act_a, ref_out(k_a, g_a, 0));
    chk("model_b", k_a, act_b, ref_out(k_a, g_b, 0));
    chk("model_s", k_s, act_s, ref_out(k_s, g_s, bias_s));
  endtask

  // Advance one Clk cycle and compare every instance mid-cycle.
  task automatic step();
    @(posedge Clk);
    @(negedge Clk);
    check_models();
  endtask

  task automatic reset_ab();
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
  endtask

  task automatic reset_s();
    rst_s_n = 1'b0;
    bias_s  = 0;
    step(); step();
    rst_s_n = 1'b1;
  endtask

  // Hard stop in case a wait loop is ever unbounded.
  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[15];
    int n, m, w, gap, fs_cnt, fs_wide, vs_low, blank_hi;
    logic prev_fs;

    g_a = '{640, 16, 96, 48, 480, 10, 2, 33, 1};
    g_b = '{640, 16, 96, 48, 480, 10, 2, 33, 4};
    g_s = '{8, 2, 3, 3, 6, 1, 2, 1, 2};

    // {edges since release, DrawX, DrawY, hs, vs, blank} for PIPE_DELAY = 1
    tbl[0]  = '{0,    0,   0, 1'b1, 1'b1, 1'b0};
    tbl[1]  = '{1,    0,   0, 1'b1, 1'b1, 1'b1};
    tbl[2]  = '{2,    1,   0, 1'b1, 1'b1, 1'b1};
    tbl[3]  = '{3,    1,   0, 1'b1, 1'b1, 1'b1};
    tbl[4]  = '{4,    2,   0, 1'b1, 1'b1, 1'b1};
    tbl[5]  = '{1280, 640, 0, 1'b1, 1'b1, 1'b1};
    tbl[6]  = '{1281, 640, 0, 1'b1, 1'b1, 1'b0};
    tbl[7]  = '{1312, 656, 0, 1'b1, 1'b1, 1'b0};
    tbl[8]  = '{1313, 656, 0, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{1504, 752, 0, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{1505, 752, 0, 1'b1, 1'b1, 1'b0};
    tbl[11] = '{1599, 799, 0, 1'b1, 1'b1, 1'b0};
    tbl[12] = '{1600, 0,   1, 1'b1, 1'b1, 1'b0};
    tbl[13] = '{1601, 0,   1, 1'b1, 1'b1, 1'b1};
    tbl[14] = '{1602, 1,   1, 1'b1, 1'b1, 1'b1};

    @(negedge Clk);
    check_models();
    rst_s_n = 1'b0;
    reset_ab();
    rst_s_n = 1'b1;

    // Table-driven walk through the first line of the full-size raster.
    for (int i = 0; i < 15; i++) begin
      n = 0;
      while (k_a < tbl[i].k && n < 4000) begin step(); n++; end
      total++;
      if (k_a == tbl[i].k && a_x == 10'(tbl[i].x) && a_y == 10'(tbl[i].y) &&
          a_hs === tbl[i].hs && a_vs === tbl[i].vs && a_blank === tbl[i].blank)
        passed++;
      else
        $display("FAIL vec%0d k=%0d: got x=%0d y=%0d hs=%0d vs=%0d blank=%0d, expected x=%0d y=%0d hs=%0d vs=%0d blank=%0d",
                 i, k_a, a_x, a_y, a_hs, a_vs, a_blank,
                 tbl[i].x, tbl[i].y, tbl[i].hs, tbl[i].vs, tbl[i].blank);
    end

    // Four-deep pipeline: hs latency, width and line period.
    reset_ab();
    n = 0;
    while (b_x != 10'd656 && n < 2000) begin step(); n++; end
    chk_int("b_reach_656", int'(b_x), 656);
    m = 0;
    while (b_hs !== 1'b0 && m < 10) begin step(); m++; end
    chk_int("b_hs_latency", m, 4);
    w = 0;
    while (b_hs === 1'b0 && w < 400) begin step(); w++; end
    chk_int("b_hs_low_width", w, 192);
    gap = 0;
    while (b_hs === 1'b1 && gap < 2000) begin step(); gap++; end
    chk_int("b_line_period", w + gap, 1600);

    // Reduced geometry: three whole frames of strobe and pulse statistics.
    reset_s();
    fs_cnt = 0; fs_wide = 0; vs_low = 0; blank_hi = 0; prev_fs = 1'b0;
    for (int i = 0; i < 960; i++) begin
      step();
      if (s_fs === 1'b1) fs_cnt++;
      if (s_fs === 1'b1 && prev_fs === 1'b1) fs_wide++;
      if (s_vs === 1'b0) vs_low++;
      if (s_blank === 1'b1) blank_hi++;
      prev_fs = s_fs;
    end
    chk_int("s_frame_pulses", fs_cnt, 3);
    chk_int("s_wide_pulses", fs_wide, 0);
    chk_int("s_vs_low_cycles", vs_low, 192);
    chk_int("s_blank_cycles", blank_hi, 288);
    chk_int("s_deltatime_3", int'(s_dt), 3);

    // Preload the frame counter to its maximum and cross one frame boundary.
    force dut_s.r_deltatime = 13'd8191;
    #1;
    release dut_s.r_deltatime;
    bias_s = (8191 + 8192 - ((k_s / 2) / 160) % 8192) % 8192;
    step();
    chk_int("s_deltatime_preload", int'(s_dt), 8191);
    n = 0;
    while (k_s < 1281 && n < 1000) begin step(); n++; end
    chk_int("s_deltatime_wrap", int'(s_dt), 0);

    // Random run lengths with asynchronous resets landing mid-cycle.
    for (int seg = 0; seg < 6; seg++) begin
      int unsigned len;
      len = $urandom_range(300, 2500);
      for (int i = 0; i < int'(len); i++) step();
      if ($urandom_range(0, 1) == 1) @(posedge Clk);
      #($urandom_range(1, 8));
      rst_n   = 1'b0;
      rst_s_n = 1'b0;
      bias_s  = 0;
      #1;
      check_models();
      step();
      rst_n   = 1'b1;
      rst_s_n = 1'b1;
    end
    for (int i = 0; i < 20; i++) step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
